// File: rtl/uo_out_arbiter.sv
// Round-robin arbiter sharing one registered output byte among NREQ
// requesters. Each granted byte is held on out_data for HOLD cycles.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | busy=0; may grant the next valid requester when ena=1
// S_HOLD | busy=1; hold window running, req_ready all low, timer counts down
module uo_out_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   parameter int HOLD = 2,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic [DW-1:0]      out_data,
   output logic               out_strobe,
   output logic [IDW-1:0]     out_grant_id,
   output logic               busy
);

   localparam int CW = 8;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IDW-1:0]   last_grant_q, last_grant_d;
   logic [DW-1:0]    out_data_q, out_data_d;
   logic [IDW-1:0]   grant_id_q, grant_id_d;
   logic             strobe_q, strobe_d;

   logic             found;
   logic [IDW-1:0]   win_idx;
   logic [IDW-1:0]   cur;
   logic             grant_en;
   logic [DW-1:0]    sel_data;

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cur     = last_grant_q;
      for (int k = 0; k < NREQ; k++) begin
         cur = (cur == IDW'(NREQ - 1)) ? '0 : cur + IDW'(1);
         if (!found && req_valid[cur]) begin
            found   = 1'b1;
            win_idx = cur;
         end
      end
   end

   // Ready goes to the winner only; it never looks at req_data.
   always_comb begin
      grant_en  = (state_q == S_IDLE) && ena && found;
      req_ready = '0;
      if (grant_en) begin
         req_ready[win_idx] = 1'b1;
      end
   end

   // Mux the winning requester's byte.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == IDW'(i)) begin
            sel_data = req_data[i*DW +: DW];
         end
      end
   end

   // Next-state, hold timer and output register updates.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      out_data_d   = out_data_q;
      grant_id_d   = grant_id_q;
      strobe_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant_en) begin
               out_data_d   = sel_data;
               grant_id_d   = win_idx;
               last_grant_d = win_idx;
               strobe_d     = 1'b1;
               cnt_d        = CW'(HOLD - 1);
               // HOLD=1 stays in IDLE so a grant can occur every cycle.
               if (HOLD > 1) begin
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (cnt_q <= CW'(1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and output registers; reset points the pointer at NREQ-1 so
   // requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         last_grant_q <= IDW'(NREQ - 1);
         out_data_q   <= '0;
         grant_id_q   <= '0;
         strobe_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         out_data_q   <= out_data_d;
         grant_id_q   <= grant_id_d;
         strobe_q     <= strobe_d;
      end
   end

   assign out_data     = out_data_q;
   assign out_strobe   = strobe_q;
   assign out_grant_id = grant_id_q;
   assign busy         = (state_q == S_HOLD);

endmodule

// File: doc/uo_out_arbiter.md
Name: uo_out_arbiter

Overview:
- Shares the registered 8-bit output byte among NREQ on-chip requesters using round-robin arbitration.
- Each requester offers one byte with a valid/ready handshake. The granted byte is registered onto out_data and held for HOLD cycles so external logic can sample it.
- Sits between internal producer blocks and the top-level uo_out pins.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data width per requester
HOLD, 2, cycles each granted byte is held before the next grant (1..255)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  arbitration enable; low blocks new grants
req_valid  input  NREQ  per-requester data valid
req_data  input  NREQ*DW  packed data; requester i at bits [i*DW +: DW]
req_ready  output  NREQ  per-requester accept; combinational
out_data  output  DW  registered granted byte
out_strobe  output  1  one-cycle pulse: new byte on out_data
out_grant_id  output  clog2(NREQ)  index of the requester whose byte is on out_data
busy  output  1  hold window active

Behaviour:
Clock, reset and interface:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: out_data=0, out_strobe=0, out_grant_id=0, busy=0, hold counter=0.
- The round-robin pointer resets to last_grant=NREQ-1, so requester 0 has top priority after reset.
- Reset asserted mid-hold aborts the hold immediately. No partial state survives.

State machine:
- IDLE (busy=0) and HOLD (busy=1).

Grant decision in IDLE with ena=1:
- The winner is the first i with req_valid[i]=1, searching from (last_grant+1) mod NREQ upward with wrap-around.
- req_ready[winner]=1. All other req_ready bits are 0.
- req_ready depends only on state, ena, req_valid and the pointer. It never depends on req_data.

Transfer at a rising edge with req_valid[i] & req_ready[i]:
- out_data <= req_data[i].
- out_grant_id <= i.
- last_grant <= i.
- out_strobe <= 1 for exactly one cycle.
- Hold counter loads HOLD-1.
- If HOLD>1, go to HOLD. If HOLD=1, stay in IDLE, so back-to-back grants every cycle are legal.

HOLD state:
- req_ready = 0 for all requesters.
- The counter decrements each cycle. When it reaches 0, return to IDLE.
- Earliest next transfer is at edge T+HOLD, where T is the previous transfer edge.
- busy=1 exactly for cycles T+1 .. T+HOLD-1.

Other rules:
- ena=0: no grants and req_ready all 0. An in-progress hold still counts down and completes.
- No valid requesters in IDLE: outputs hold their last values. out_data is not cleared.
- Requesters must hold req_valid and req_data stable until accepted. Dropping valid before acceptance simply withdraws the request; no error is flagged.
- A single requester that continuously asserts valid is granted every HOLD cycles with no starvation of others. Any waiting requester is granted within NREQ grants.
- out_strobe and busy are registered. out_data changes only on transfer edges.

Test Plan:
- Reset with valid=4'b1111, data 0x11/0x22/0x33/0x44 (HOLD=2) -> first grant is id 0, out_data=0x11; then 0x22, 0x33, 0x44, 0x11 at strobes spaced 2 cycles apart.
- Only req 2 valid, data 0xA5, HOLD=1 -> req_ready[2] high every cycle; out_strobe high continuously; out_data=0xA5, out_grant_id=2.
- Round-robin wrap: last_grant=3, valid=4'b0101 -> grant 0, then 2, then 0; never twice in a row while another is valid.
- HOLD=4, req 1 valid throughout with data 0x5C -> strobes at edges T, T+4, T+8; busy high for 3 cycles after each; req_ready[1]=0 while busy.
- ena deasserted one cycle after a grant -> hold completes, no further strobes while ena=0; grant resumes the first cycle ena=1 in IDLE.
- Assert rst_n=0 mid-hold with out_data=0x7E -> out_data=0, busy=0, strobe=0 immediately (asynchronous); after release req 0 wins first.
